// File: rtl/telemetry_tx_scheduler_pkg.sv
// Shared constants, state encoding and snapshot layout for the telemetry
// transmit scheduler.
package telemetry_tx_scheduler_pkg;

  localparam int unsigned FRAME_LEN   = 9;
  localparam int unsigned ACK_TIMEOUT = 16;
  localparam logic [7:0]  LOG_HDR     = 8'hA5;
  localparam logic [7:0]  ALARM_HDR   = 8'h5A;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = $clog2(FRAME_LEN);
  localparam int unsigned TMR_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] hdr;
    logic       shutdown;
    logic       alarm;
    logic [7:0] temp;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [4:0] days;
    logic [3:0] months;
  } snapshot_t;

  // Frame byte at position idx; the last slot carries the running checksum.
  function automatic logic [BYTE_W-1:0] frame_byte(input snapshot_t s,
                                                   input logic [IDX_W-1:0] idx,
                                                   input logic [BYTE_W-1:0] csum);
    logic [BYTE_W-1:0] b;
    case (idx)
      IDX_W'(0): b = s.hdr;
      IDX_W'(1): b = {6'b0, s.shutdown, s.alarm};
      IDX_W'(2): b = s.temp;
      IDX_W'(3): b = {2'b0, s.seconds};
      IDX_W'(4): b = {2'b0, s.minutes};
      IDX_W'(5): b = {3'b0, s.hours};
      IDX_W'(6): b = {3'b0, s.days};
      IDX_W'(7): b = {4'b0, s.months};
      default:   b = csum;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/telemetry_tx_scheduler_if.sv
// Byte-wide start/busy handshake between the scheduler and the UART transmitter.
interface telemetry_tx_scheduler_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (output tx_data, output tx_start, input tx_busy);
  modport slave  (input tx_data, input tx_start, output tx_busy);

endinterface

// File: rtl/telemetry_tx_scheduler_frame_builder.sv
// Holds the frame snapshot and running checksum; muxes out the byte at idx.
module telemetry_tx_scheduler_frame_builder
  import telemetry_tx_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  snapshot_t         i_snap,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_accum,
  output logic [BYTE_W-1:0] o_byte_c
);

  snapshot_t         r_snap;
  logic [BYTE_W-1:0] r_csum;
  logic [BYTE_W-1:0] w_byte;

  assign w_byte   = frame_byte(r_snap, i_idx, r_csum);
  assign o_byte_c = w_byte;

  // Checksum restarts on every snapshot and absorbs each byte as it is sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= '0;
      r_csum <= '0;
    end else if (i_load) begin
      r_snap <= i_snap;
      r_csum <= '0;
    end else if (i_accum) begin
      r_csum <= r_csum ^ w_byte;
    end
  end

endmodule

// File: rtl/telemetry_tx_scheduler.sv
// Arbitrates log/alarm frame requests and feeds frames byte-by-byte to the
// shared UART transmitter with an ack timeout.
module telemetry_tx_scheduler
  import telemetry_tx_scheduler_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pulse,
  input  logic                      alarm,
  input  logic                      shutdown,
  input  logic [7:0]                temp,
  input  logic [5:0]                seconds,
  input  logic [5:0]                minutes,
  input  logic [4:0]                hours,
  input  logic [4:0]                days,
  input  logic [3:0]                months,
  telemetry_tx_scheduler_if.master  tx_bus,
  output logic                      frame_active,
  output logic                      frame_abort,
  output logic [CNT_W-1:0]          drop_count
);

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [TMR_W-1:0]  r_timer, w_timer_nxt;
  logic [BYTE_W-1:0] r_tx_data, w_tx_data_nxt;
  logic              r_tx_start, w_tx_start_nxt;
  logic              r_frame_active, w_frame_active_nxt;
  logic              r_frame_abort, w_frame_abort_nxt;
  logic [CNT_W-1:0]  r_drop_count;
  logic              r_alarm_q, r_log_pend, r_alarm_pend;

  logic              w_pulse_ok, w_alarm_edge, w_alarm_any, w_log_any;
  logic              w_take_alarm, w_take_log, w_load, w_accum;
  logic [BYTE_W-1:0] w_byte;
  snapshot_t         w_snap;

  // A same-cycle request counts as pending so IDLE can accept it immediately.
  assign w_pulse_ok   = pulse & ~shutdown;
  assign w_alarm_edge = alarm & ~r_alarm_q;
  assign w_alarm_any  = r_alarm_pend | w_alarm_edge;
  assign w_log_any    = r_log_pend | w_pulse_ok;
  assign w_load       = w_take_alarm | w_take_log;

  assign w_snap = '{hdr:      (w_take_alarm ? ALARM_HDR : LOG_HDR),
                    shutdown: shutdown,
                    alarm:    alarm,
                    temp:     temp,
                    seconds:  seconds,
                    minutes:  minutes,
                    hours:    hours,
                    days:     days,
                    months:   months};

  telemetry_tx_scheduler_frame_builder u_tx_frame_builder (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_snap   (w_snap),
    .i_idx    (r_idx),
    .i_accum  (w_accum),
    .o_byte_c (w_byte)
  );

  always_comb begin
    w_state_nxt        = r_state;
    w_idx_nxt          = r_idx;
    w_timer_nxt        = r_timer;
    w_tx_data_nxt      = r_tx_data;
    w_tx_start_nxt     = 1'b0;
    w_frame_active_nxt = r_frame_active;
    w_frame_abort_nxt  = 1'b0;
    w_take_alarm       = 1'b0;
    w_take_log         = 1'b0;
    w_accum            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_alarm_any) begin
          w_take_alarm = 1'b1;
        end else if (w_log_any) begin
          w_take_log = 1'b1;
        end
        if (w_alarm_any || w_log_any) begin
          w_idx_nxt          = '0;
          w_frame_active_nxt = 1'b1;
          w_state_nxt        = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_bus.tx_busy) begin
          w_tx_data_nxt  = w_byte;
          w_tx_start_nxt = 1'b1;
          w_accum        = 1'b1;
          w_timer_nxt    = '0;
          w_state_nxt    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (tx_bus.tx_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
          w_frame_abort_nxt  = 1'b1;
          w_frame_active_nxt = 1'b0;
          w_state_nxt        = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_bus.tx_busy) begin
          if (r_idx == IDX_W'(FRAME_LEN - 1)) begin
            w_frame_active_nxt = 1'b0;
            w_state_nxt        = ST_IDLE;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = ST_SEND;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_timer        <= '0;
      r_tx_data      <= '0;
      r_tx_start     <= 1'b0;
      r_frame_active <= 1'b0;
      r_frame_abort  <= 1'b0;
      r_drop_count   <= '0;
      r_alarm_q      <= 1'b0;
      r_log_pend     <= 1'b0;
      r_alarm_pend   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_timer        <= w_timer_nxt;
      r_tx_data      <= w_tx_data_nxt;
      r_tx_start     <= w_tx_start_nxt;
      r_frame_active <= w_frame_active_nxt;
      r_frame_abort  <= w_frame_abort_nxt;
      r_alarm_q      <= alarm;
      // A slot freed this cycle can be refilled by a request in the same cycle.
      r_log_pend     <= w_take_log   ? (r_log_pend & w_pulse_ok)     : w_log_any;
      r_alarm_pend   <= w_take_alarm ? (r_alarm_pend & w_alarm_edge) : w_alarm_any;
      if (w_pulse_ok && r_log_pend && !w_take_log && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + CNT_W'(1);
      end
    end
  end

  assign tx_bus.tx_data  = r_tx_data;
  assign tx_bus.tx_start = r_tx_start;
  assign frame_active    = r_frame_active;
  assign frame_abort     = r_frame_abort;
  assign drop_count      = r_drop_count;

endmodule

// File: tb/tb_telemetry_tx_scheduler.sv
// Directed self-checking bench for telemetry_tx_scheduler with a simple
// start/busy transmitter model.
module tb_telemetry_tx_scheduler;

  localparam int BUSY_LEN = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse = 1'b0;
  logic       alarm = 1'b0;
  logic       shutdown = 1'b0;
  logic [7:0] temp = 8'h00;
  logic [5:0] seconds = 6'd0;
  logic [5:0] minutes = 6'd0;
  logic [4:0] hours = 5'd0;
  logic [4:0] days = 5'd0;
  logic [3:0] months = 4'd0;
  logic       frame_active;
  logic       frame_abort;
  logic [7:0] drop_count;

  telemetry_tx_scheduler_if u_tx_if ();

  telemetry_tx_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .pulse        (pulse),
    .alarm        (alarm),
    .shutdown     (shutdown),
    .temp         (temp),
    .seconds      (seconds),
    .minutes      (minutes),
    .hours        (hours),
    .days         (days),
    .months       (months),
    .tx_bus       (u_tx_if),
    .frame_active (frame_active),
    .frame_abort  (frame_abort),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: busy rises one cycle after a start strobe for BUSY_LEN cycles.
  logic       tx_silent = 1'b0;
  logic       pend_start = 1'b0;
  int         busy_left = 0;
  logic [7:0] q_bytes[$];
  int         q_cyc[$];
  int         n_abort = 0;

  initial u_tx_if.tx_busy = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      u_tx_if.tx_busy = 1'b0;
      pend_start      = 1'b0;
      busy_left       = 0;
    end else begin
      if (pend_start) begin
        u_tx_if.tx_busy = 1'b1;
        busy_left       = BUSY_LEN - 1;
        pend_start      = 1'b0;
      end else if (u_tx_if.tx_busy) begin
        if (busy_left == 0) u_tx_if.tx_busy = 1'b0;
        else busy_left = busy_left - 1;
      end
      if (u_tx_if.tx_start) begin
        q_bytes.push_back(u_tx_if.tx_data);
        q_cyc.push_back(cyc);
        if (!tx_silent) pend_start = 1'b1;
      end
      if (frame_abort) n_abort = n_abort + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic strobe_pulse();
    pulse = 1'b1;
    tick(1);
    pulse = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    q_bytes.delete();
    q_cyc.delete();
    n_abort = 0;
  endtask

  task automatic wait_quiet(input int max_c, input string tag);
    int quiet = 0;
    int t = 0;
    while (quiet < 6 && t < max_c) begin
      tick(1);
      t = t + 1;
      if (frame_active || u_tx_if.tx_busy) quiet = 0;
      else quiet = quiet + 1;
    end
    check({tag, "_settle"}, 32'(quiet >= 6), 32'd1);
  endtask

  logic [7:0] exp_t1 [9] = '{8'hA5, 8'h00, 8'h3C, 8'h38, 8'h22, 8'h0C, 8'h07, 8'h03, 8'h8B};

  initial begin
    int t;
    int s_cyc;
    int a_cyc;
    int min_gap;

    // Reset state
    tick(3);
    check("rst_tx_start", 32'(u_tx_if.tx_start), 32'd0);
    check("rst_tx_data", 32'(u_tx_if.tx_data), 32'd0);
    check("rst_frame_active", 32'(frame_active), 32'd0);
    check("rst_frame_abort", 32'(frame_abort), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    reset = 1'b0;
    tick(7);

    // Log frame, latency and snapshot isolation
    temp = 8'h3C; seconds = 6'd56; minutes = 6'd34; hours = 5'd12; days = 5'd7; months = 4'd3;
    strobe_pulse();
    check("lat_n1_start", 32'(u_tx_if.tx_start), 32'd0);
    check("lat_n1_active", 32'(frame_active), 32'd1);
    tick(1);
    check("lat_n2_start", 32'(u_tx_if.tx_start), 32'd1);
    check("lat_n2_data", 32'(u_tx_if.tx_data), 32'hA5);
    seconds = 6'd10;
    t = 0;
    while (frame_active && t < 500) begin
      tick(1);
      t = t + 1;
    end
    check("t1_end_busy_low", 32'(u_tx_if.tx_busy), 32'd0);
    check("t1_end_active", 32'(frame_active), 32'd0);
    check("t1_nbytes", 32'(q_bytes.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < q_bytes.size()) check($sformatf("t1_byte%0d", i), 32'(q_bytes[i]), 32'(exp_t1[i]));
    end
    min_gap = 1000;
    for (int i = 1; i < q_cyc.size(); i++) begin
      if (q_cyc[i] - q_cyc[i-1] < min_gap) min_gap = q_cyc[i] - q_cyc[i-1];
    end
    check("t1_strobe_gap_ge2", 32'(min_gap >= 2), 32'd1);
    check("t1_drop", 32'(drop_count), 32'd0);
    seconds = 6'd56;
    wait_quiet(100, "t1");

    // Alarm edge and pulse together: alarm first, then log
    do_reset();
    alarm = 1'b1;
    strobe_pulse();
    wait_quiet(1500, "t2");
    check("t2_nbytes", 32'(q_bytes.size()), 32'd18);
    if (q_bytes.size() == 18) begin
      check("t2_hdr0", 32'(q_bytes[0]), 32'h5A);
      check("t2_flags0", 32'(q_bytes[1]), 32'h01);
      check("t2_hdr1", 32'(q_bytes[9]), 32'hA5);
      check("t2_temp1", 32'(q_bytes[11]), 32'h3C);
    end
    check("t2_drop", 32'(drop_count), 32'd0);
    alarm = 1'b0;
    tick(2);

    // Three pulses during a frame: one extra frame, two drops
    do_reset();
    strobe_pulse();
    tick(4);
    for (int i = 0; i < 3; i++) begin
      strobe_pulse();
      tick(2);
    end
    check("t3_drop_mid", 32'(drop_count), 32'd2);
    wait_quiet(1500, "t3");
    check("t3_nbytes", 32'(q_bytes.size()), 32'd18);
    if (q_bytes.size() == 18) check("t3_hdr1", 32'(q_bytes[9]), 32'hA5);
    check("t3_drop_end", 32'(drop_count), 32'd2);

    // Drop counter saturation
    do_reset();
    strobe_pulse();
    for (int i = 0; i < 300; i++) begin
      strobe_pulse();
      tick(1);
    end
    check("t3_drop_sat", 32'(drop_count), 32'd255);
    wait_quiet(3000, "t3s");
    check("t3_drop_sat_hold", 32'(drop_count), 32'd255);

    // Ack timeout abort, then pending request served
    do_reset();
    tx_silent = 1'b1;
    strobe_pulse();
    tick(1);
    check("t4_first_start", 32'(u_tx_if.tx_start), 32'd1);
    s_cyc = cyc;
    tick(2);
    strobe_pulse();
    t = 0;
    while (!frame_abort && t < 100) begin
      tick(1);
      t = t + 1;
    end
    a_cyc = cyc;
    check("t4_abort_seen", 32'(frame_abort), 32'd1);
    check("t4_abort_delay", 32'(a_cyc - s_cyc), 32'd16);
    check("t4_abort_active", 32'(frame_active), 32'd0);
    tx_silent = 1'b0;
    tick(1);
    check("t4_abort_1cyc", 32'(frame_abort), 32'd0);
    wait_quiet(1000, "t4");
    check("t4_nbytes", 32'(q_bytes.size()), 32'd10);
    if (q_bytes.size() >= 2) begin
      check("t4_retry_cyc", 32'(q_cyc[1] - a_cyc), 32'd2);
      check("t4_retry_hdr", 32'(q_bytes[1]), 32'hA5);
    end
    check("t4_n_abort", 32'(n_abort), 32'd1);

    // Shutdown: pulses ignored, alarm still served with shutdown flag
    do_reset();
    shutdown = 1'b1;
    strobe_pulse();
    tick(4);
    strobe_pulse();
    tick(30);
    check("t5_no_frame", 32'(q_bytes.size()), 32'd0);
    check("t5_no_drop", 32'(drop_count), 32'd0);
    check("t5_idle", 32'(frame_active), 32'd0);
    alarm = 1'b1;
    tick(1);
    wait_quiet(1000, "t5");
    check("t5_nbytes", 32'(q_bytes.size()), 32'd9);
    if (q_bytes.size() == 9) begin
      check("t5_hdr", 32'(q_bytes[0]), 32'h5A);
      check("t5_flags", 32'(q_bytes[1]), 32'h03);
    end
    alarm = 1'b0;
    shutdown = 1'b0;
    tick(2);

    // Reset mid-frame after byte 4
    do_reset();
    strobe_pulse();
    tick(3);
    strobe_pulse();
    tick(2);
    strobe_pulse();
    check("t6_drop_pre", 32'(drop_count), 32'd1);
    t = 0;
    while (q_bytes.size() < 5 && t < 1000) begin
      tick(1);
      t = t + 1;
    end
    check("t6_reached_byte4", 32'(q_bytes.size()), 32'd5);
    reset = 1'b1;
    tick(1);
    check("t6_rst_start", 32'(u_tx_if.tx_start), 32'd0);
    check("t6_rst_active", 32'(frame_active), 32'd0);
    check("t6_rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;
    tick(100);
    check("t6_no_more_strobes", 32'(q_bytes.size()), 32'd5);
    check("t6_still_idle", 32'(frame_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/telemetry_tx_scheduler.md
Name: telemetry_tx_scheduler

Overview:
Sequences the shared UART transmitter between two requesters: periodic temperature log frames (on the controller's sample pulse) and alarm frames (on the controller's alarm rising edge). On acceptance it snapshots temperature, the digital-clock timestamp and the status flags, then feeds a 9-byte frame to the transmitter one byte at a time over a start/busy handshake. It sits between the controller/digital clock and the transmitter. It holds one pending slot per requester and counts dropped log requests.

Parameters:
FRAME_LEN, 9, bytes per frame (header, flags, temp, sec, min, hr, day, month, checksum)
ACK_TIMEOUT, 16, cycles allowed for tx_busy to rise after tx_start before the frame is aborted
LOG_HDR, 8'hA5, header byte for log frames
ALARM_HDR, 8'h5A, header byte for alarm frames

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
pulse  in  1  log request (1-cycle strobe from controller)
alarm  in  1  alarm level from controller; rising edge = alarm request
shutdown  in  1  shutdown level from controller
temp  in  8  current temperature code
seconds  in  6  timestamp seconds
minutes  in  6  timestamp minutes
hours  in  5  timestamp hours
days  in  5  timestamp days
months  in  4  timestamp months
tx_busy  in  1  transmitter busy
tx_data  out  8  byte to transmit, valid while tx_start=1
tx_start  out  1  1-cycle start strobe to transmitter
frame_active  out  1  high from snapshot until the frame completes or aborts
frame_abort  out  1  1-cycle pulse on ACK_TIMEOUT expiry
drop_count  out  8  saturating count of dropped log requests

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. On reset: tx_data=0, tx_start=0, frame_active=0, frame_abort=0, drop_count=0, both pending flags clear, alarm edge register clear, state IDLE. Reset mid-frame abandons the frame with no further tx_start.
- Requests:
  - pulse=1 with shutdown=0 sets log_pend. If log_pend is already set, drop_count increments instead, saturating at 255.
  - pulse while shutdown=1 is ignored and not counted.
  - alarm rising edge (alarm & ~alarm_q) sets alarm_pend. A repeated edge while alarm_pend is set is absorbed and not counted.
- Arbitration: only in IDLE; a frame is never preempted. alarm_pend has priority over log_pend. Simultaneous alarm edge and pulse in IDLE sends the alarm frame first, then the log frame.
- States:
  - IDLE: if any pending flag is set, take the winner, clear its flag, snapshot all inputs and the header, zero the checksum, set byte index to 0, assert frame_active, go to SEND.
  - SEND: when tx_busy=0, drive tx_data=byte[idx], tx_start=1 for exactly one cycle, XOR the byte into the checksum, clear the timer, go to WAIT_ACK. While tx_busy=1, hold in SEND.
  - WAIT_ACK: go to WAIT_DONE when tx_busy=1. If the timer reaches ACK_TIMEOUT, pulse frame_abort, drop frame_active, go to IDLE.
  - WAIT_DONE: when tx_busy=0, then if idx==FRAME_LEN-1 drop frame_active and go to IDLE; else idx+1 and go to SEND.
- Frame bytes (from the snapshot):
  - 0: header
  - 1: {6'b0, shutdown, alarm}
  - 2: temp
  - 3: {2'b0, seconds}
  - 4: {2'b0, minutes}
  - 5: {3'b0, hours}
  - 6: {3'b0, days}
  - 7: {4'b0, months}
  - 8: XOR of bytes 0-7
- Latency: a request strobed in cycle n while in IDLE with tx_busy=0 gives state SEND at n+1 and tx_start=1 in cycle n+2. No back-to-back tx_start: at least 2 cycles between strobes. Timestamp changes after the snapshot do not affect the frame in flight.
- Requests arriving during a frame are still latched or counted.

Decomposition:
- Shared constants (header codes, FRAME_LEN, state encoding) go in the existing parameters include alongside the baud and parity defines.
- One natural sub-module: tx_frame_builder, a combinational byte mux plus registered snapshot indexed by idx. The FSM and arbiter stay in the top.

Test Plan:
- pulse at cycle 10, temp=8'h3C, time 12:34:56 on day 7, month 3, tx model asserts busy 1 cycle after start for 20 cycles -> 9 strobes with bytes A5,00,3C,38,22,0C,07,03, then the XOR checksum; frame_active low after the last busy falls.
- alarm rises in the same cycle as pulse -> first frame header 5A with flags byte 01, then a log frame header A5; drop_count=0.
- 3 pulses during one frame -> exactly one extra log frame after it, drop_count=2. 300 such drops -> drop_count saturates at 255.
- tx model never raises busy -> frame_abort pulses exactly ACK_TIMEOUT cycles after the first tx_start, state returns to IDLE, and the pending request is then served.
- shutdown=1 with pulse -> no frame, no drop count. alarm edge under shutdown -> alarm frame with flags byte 03.
- reset asserted after byte 4 -> next cycle tx_start=0, frame_active=0, drop_count=0, and no further strobes without a new request.
